// File: rtl/product_accumulator_if.sv
// product_accumulator_if: product-in / result-out handshake bundle for the product accumulator.
interface product_accumulator_if #(
    parameter int ACC_W = 12,
    parameter int CNT_W = 4
);
    logic             start;
    logic [CNT_W-1:0] len;
    logic             prod_valid;
    logic [7:0]       product;
    logic             prod_ready;
    logic             acc_valid;
    logic [ACC_W-1:0] acc_out;
    logic             overflow;
    logic             acc_ready;
    logic             busy;
    modport master (
        output start, len, prod_valid, product, acc_ready,
        input  prod_ready, acc_valid, acc_out, overflow, busy
    );
    modport slave (
        input  start, len, prod_valid, product, acc_ready,
        output prod_ready, acc_valid, acc_out, overflow, busy
    );
endinterface

// File: rtl/product_accumulator.sv
// product_accumulator: sums a programmed number of 8-bit products and hands off the result.
module product_accumulator #(
    parameter int ACC_W = 12,
    parameter int CNT_W = 4
) (
    input logic clk,
    input logic rst,
    product_accumulator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
    state_t           r_state, w_next;
    logic [ACC_W-1:0] r_acc;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;
    logic             w_xfer;
    logic [ACC_W:0]   w_sum;
    assign w_xfer = bus.prod_valid && r_state == ACCUM;
    assign w_sum = {1'b0, r_acc} + {{(ACC_W-7){1'b0}}, bus.product};
    // Handshake outputs decode state only, so no input reaches an output combinationally.
    assign bus.prod_ready = r_state == ACCUM;
    assign bus.acc_valid = r_state == DONE;
    assign bus.busy = r_state != IDLE;
    assign bus.acc_out = r_acc;
    assign bus.overflow = r_ovf;
    always_comb begin
        w_next = r_state;
        if (r_state == IDLE && bus.start)
            w_next = bus.len == '0 ? DONE : ACCUM;
        else if (w_xfer && r_cnt == CNT_W'(1))
            w_next = DONE;
        else if (r_state == DONE && bus.acc_ready)
            w_next = IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_acc <= '0;
            r_ovf <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && bus.start) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
                r_cnt <= bus.len;
            end else if (w_xfer) begin
                r_acc <= w_sum[ACC_W-1:0];
                r_ovf <= r_ovf | w_sum[ACC_W];
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end
endmodule
